// File: rtl/jk_pkg.sv
// Shared types and the JK excitation helper for the JK excitation driver.
package jk_pkg;

  localparam int unsigned WORD_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    StInit  = 2'd0,
    StIdle  = 2'd1,
    StDrive = 2'd2
  } jk_state_e;

  // Returns {J, K} that moves a JK flip-flop from q to t; dc fills the don't-care slot.
  function automatic logic [1:0] jk_excite(input logic q, input logic t, input logic dc);
    logic [1:0] jk;
    jk = 2'b00;
    unique case ({q, t})
      2'b00: jk = {1'b0, dc};
      2'b01: jk = {1'b1, dc};
      2'b10: jk = {dc, 1'b1};
      2'b11: jk = {dc, 1'b0};
      default: jk = 2'b00;
    endcase
    return jk;
  endfunction

endpackage

// File: rtl/jk_mismatch_checker.sv
// Compares flip-flop feedback against the driver's Q model; sticky flag plus saturating count.
module jk_mismatch_checker #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_q_fb,
  input  logic             i_q_model,
  output logic             o_mismatch,
  output logic [CNT_W-1:0] o_err_count
);

  logic             r_mismatch;
  logic [CNT_W-1:0] r_count;
  logic             w_miss;

  assign w_miss = i_en && (i_q_fb != i_q_model);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mismatch <= 1'b0;
      r_count    <= '0;
    end else if (w_miss) begin
      r_mismatch <= 1'b1;
      if (r_count != '1) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign o_mismatch  = r_mismatch;
  assign o_err_count = r_count;

endmodule

// File: rtl/jk_excitation_driver.sv
// Serialises target words LSB-first into registered J/K drive for a downstream JK flip-flop.
// Optional feedback checking is enabled with the JKD_CHECK_EN macro.
module jk_excitation_driver
  import jk_pkg::*;
#(
  parameter int unsigned WORD_W = WORD_W_DEFAULT,
  parameter int unsigned DC_ONE = 0,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [WORD_W-1:0] i_in_data,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  output logic              o_j,
  output logic              o_k,
  output logic              o_busy,
  input  logic              i_q_fb,
  output logic              o_mismatch,
  output logic [CNT_W-1:0]  o_err_count
);

  localparam int unsigned      IDX_W    = $clog2(WORD_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);
  localparam logic             DC_BIT   = (DC_ONE != 0);

  jk_state_e         r_state, w_state_d;
  logic [WORD_W-1:0] r_shift, w_shift_d;
  logic [IDX_W-1:0]  r_idx, w_idx_d;
  logic              r_j, w_j_d;
  logic              r_k, w_k_d;
  logic              r_q_model, w_q_model_d;
  logic              w_last;
  logic              w_accept;

  // r_shift[0] is always the bit whose J/K are currently on the outputs.
  assign w_last     = (r_state == StDrive) && (r_idx == LAST_IDX);
  assign o_in_ready = (r_state == StIdle) || w_last;
  assign w_accept   = i_in_valid && o_in_ready;
  assign o_busy     = (r_state != StIdle);

  always_comb begin
    w_state_d   = r_state;
    w_shift_d   = r_shift;
    w_idx_d     = r_idx;
    w_q_model_d = r_q_model;
    w_j_d       = 1'b0;
    w_k_d       = 1'b0;
    unique case (r_state)
      StInit: begin
        w_state_d = StIdle;
      end
      StIdle: begin
        if (w_accept) begin
          w_state_d      = StDrive;
          w_shift_d      = i_in_data;
          w_idx_d        = '0;
          {w_j_d, w_k_d} = jk_excite(r_q_model, i_in_data[0], DC_BIT);
        end
      end
      StDrive: begin
        // The flip-flop takes the current bit on this edge.
        w_q_model_d = r_shift[0];
        if (!w_last) begin
          w_shift_d      = r_shift >> 1;
          w_idx_d        = r_idx + 1'b1;
          {w_j_d, w_k_d} = jk_excite(r_shift[0], r_shift[1], DC_BIT);
        end else if (w_accept) begin
          w_shift_d      = i_in_data;
          w_idx_d        = '0;
          {w_j_d, w_k_d} = jk_excite(r_shift[0], i_in_data[0], DC_BIT);
        end else begin
          w_state_d = StIdle;
        end
      end
      default: begin
        w_state_d = StInit;
      end
    endcase
  end

  // INIT drives J=0,K=1 to clear the reset-less flip-flop.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= StInit;
      r_shift   <= '0;
      r_idx     <= '0;
      r_j       <= 1'b0;
      r_k       <= 1'b1;
      r_q_model <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_shift   <= w_shift_d;
      r_idx     <= w_idx_d;
      r_j       <= w_j_d;
      r_k       <= w_k_d;
      r_q_model <= w_q_model_d;
    end
  end

  assign o_j = r_j;
  assign o_k = r_k;

`ifdef JKD_CHECK_EN
  logic w_chk_en;
  assign w_chk_en = (r_state != StInit);

  jk_mismatch_checker #(
    .CNT_W(CNT_W)
  ) u_checker (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_en       (w_chk_en),
    .i_q_fb     (i_q_fb),
    .i_q_model  (r_q_model),
    .o_mismatch (o_mismatch),
    .o_err_count(o_err_count)
  );
`else
  logic w_unused_q_fb;
  assign w_unused_q_fb = i_q_fb;
  assign o_mismatch    = 1'b0;
  assign o_err_count   = '0;
`endif

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Directed bench: two drivers (DC_ONE=0 and DC_ONE=1) share stimulus, each feeding a JK flip-flop model.
module tb_jk_excitation_driver;

  localparam int unsigned W = 8;
`ifdef JKD_CHECK_EN
  localparam bit ChkEn = 1'b1;
`else
  localparam bit ChkEn = 1'b0;
`endif

  logic         clk      = 1'b0;
  logic         rst      = 1'b1;
  logic [W-1:0] in_data  = '0;
  logic         in_valid = 1'b0;
  logic         force_fb = 1'b0;

  logic       rdy0, j0, k0, busy0, mm0;
  logic [7:0] err0;
  logic       rdy1, j1, k1, busy1, mm1;
  logic [1:0] err1;
  logic       fb0, fb1;
  // Flip-flops power up at 1 so INIT clearing them is observable.
  logic       ff0_q = 1'b1;
  logic       ff1_q = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] sw_word = 8'b1011_0010;
  logic [1:0] sw_dc0 [0:7] = '{2'b00, 2'b10, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b10};
  logic [1:0] sw_dc1 [0:7] = '{2'b01, 2'b11, 2'b11, 2'b01, 2'b11, 2'b10, 2'b11, 2'b11};
  logic [1:0] rw_dc0 [0:3] = '{2'b00, 2'b01, 2'b10, 2'b01};

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ff0_q <= (j0 & ~ff0_q) | (~k0 & ff0_q);
    ff1_q <= (j1 & ~ff1_q) | (~k1 & ff1_q);
  end

  assign fb0 = force_fb | ff0_q;
  assign fb1 = force_fb | ff1_q;

  jk_excitation_driver #(.WORD_W(W), .DC_ONE(0), .CNT_W(8)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_in_data(in_data), .i_in_valid(in_valid),
    .o_in_ready(rdy0), .o_j(j0), .o_k(k0), .o_busy(busy0), .i_q_fb(fb0),
    .o_mismatch(mm0), .o_err_count(err0)
  );

  jk_excitation_driver #(.WORD_W(W), .DC_ONE(1), .CNT_W(2)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_in_data(in_data), .i_in_valid(in_valid),
    .o_in_ready(rdy1), .o_j(j1), .o_k(k1), .o_busy(busy1), .i_q_fb(fb1),
    .o_mismatch(mm1), .o_err_count(err1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and INIT.
    step();
    check("reset jk0", {j0, k0}, 2'b01);
    check("reset jk1", {j1, k1}, 2'b01);
    check("reset busy", busy0, 1'b1);
    check("reset ready", rdy0, 1'b0);
    check("reset mismatch", mm0, 1'b0);
    check("reset errcnt", err0, 8'd0);
    rst = 1'b0;
    step();
    check("idle jk0", {j0, k0}, 2'b00);
    check("idle ready", rdy0, 1'b1);
    check("idle busy", busy0, 1'b0);
    check("init clears ff0", ff0_q, 1'b0);
    check("init clears ff1", ff1_q, 1'b0);

    // Single word, both don't-care resolutions.
    in_data  = 8'b1011_0010;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    in_data  = 8'h5A;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("sw dc0 jk bit%0d", i), {j0, k0}, sw_dc0[i]);
      check($sformatf("sw dc1 jk bit%0d", i), {j1, k1}, sw_dc1[i]);
      check($sformatf("sw ready bit%0d", i), rdy0, (i == 7));
      step();
      check($sformatf("sw ff0 q bit%0d", i), ff0_q, sw_word[i]);
      check($sformatf("sw ff1 q bit%0d", i), ff1_q, sw_word[i]);
    end
    check("sw end jk0", {j0, k0}, 2'b00);
    check("sw end ready", rdy0, 1'b1);
    check("sw end busy", busy0, 1'b0);

    // Word 8'hA5 from q=1; in_valid while not ready is ignored; reset at bit 3.
    in_data  = 8'hA5;
    in_valid = 1'b1;
    step();
    in_data = 8'h00;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rw dc0 jk bit%0d", i), {j0, k0}, rw_dc0[i]);
      check($sformatf("rw ready bit%0d", i), rdy0, 1'b0);
      if (i < 3) step();
    end
    rst = 1'b1;
    step();
    check("rw init jk0", {j0, k0}, 2'b01);
    check("rw init busy", busy0, 1'b1);
    check("rw init ready", rdy0, 1'b0);
    rst = 1'b0;
    step();
    check("rw idle jk0", {j0, k0}, 2'b00);
    check("rw idle ready", rdy0, 1'b1);
    check("rw idle busy", busy0, 1'b0);
    check("rw ff0 cleared", ff0_q, 1'b0);

    // Back-to-back 8'hFF then 8'h00 with in_valid held.
    in_data = 8'hFF;
    step();
    for (int i = 0; i < 8; i++) begin
      check($sformatf("ff dc0 jk bit%0d", i), {j0, k0}, (i == 0) ? 2'b10 : 2'b00);
      check($sformatf("ff dc1 jk bit%0d", i), {j1, k1}, (i == 0) ? 2'b11 : 2'b10);
      check($sformatf("ff ready bit%0d", i), rdy0, (i == 7));
      check($sformatf("ff busy bit%0d", i), busy0, 1'b1);
      if (i == 7) in_data = 8'h00;
      step();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 0) check("zz ff0 q first", ff0_q, 1'b1);
      check($sformatf("zz dc0 jk bit%0d", i), {j0, k0}, (i == 0) ? 2'b01 : 2'b00);
      check($sformatf("zz dc1 jk bit%0d", i), {j1, k1}, (i == 0) ? 2'b11 : 2'b01);
      check($sformatf("zz ready bit%0d", i), rdy0, (i == 7));
      step();
    end
    check("zz end jk0", {j0, k0}, 2'b00);
    check("zz end ready", rdy0, 1'b1);
    check("zz end busy", busy0, 1'b0);
    check("zz ff0 q", ff0_q, 1'b0);
    check("tracking mismatch0", mm0, 1'b0);
    check("tracking mismatch1", mm1, 1'b0);

    // Forced feedback disagreement while the model holds 0.
    force_fb = 1'b1;
    step();
    check("force mismatch0", mm0, ChkEn);
    check("force mismatch1", mm1, ChkEn);
    step();
    step();
    force_fb = 1'b0;
    check("force3 err0", err0, ChkEn ? 8'd3 : 8'd0);
    check("force3 err1", err1, ChkEn ? 8'd3 : 8'd0);
    step();
    check("no new err0", err0, ChkEn ? 8'd3 : 8'd0);
    check("sticky mismatch0", mm0, ChkEn);
    force_fb = 1'b1;
    step();
    step();
    force_fb = 1'b0;
    check("force5 err0", err0, ChkEn ? 8'd5 : 8'd0);
    check("force5 err1 saturated", err1, ChkEn ? 8'd3 : 8'd0);

    rst = 1'b1;
    step();
    check("final reset mismatch0", mm0, 1'b0);
    check("final reset err0", err0, 8'd0);
    check("final reset err1", err1, 8'd0);
    rst = 1'b0;
    step();
    check("final idle ready", rdy0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
